// File: rtl/mini_risc_ctrl_pkg.sv
// Purpose: shared encodings for the mini-RISC control sequencer (opcodes, funcs, ALU codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mini_risc_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_COMPI = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;
    localparam logic [5:0] OP_BR    = 6'd5;
    localparam logic [5:0] OP_BLTZ  = 6'd6;
    localparam logic [5:0] OP_BZ    = 6'd7;
    localparam logic [5:0] OP_BNZ   = 6'd8;
    localparam logic [5:0] OP_BL    = 6'd9;
    localparam logic [5:0] OP_NOP   = 6'd62;
    localparam logic [5:0] OP_HALT  = 6'd63;

    // R-type func codes map one-to-one onto ALU codes
    localparam logic [5:0] FN_MAX   = 6'd7;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_COMP = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SHLL = 4'd4;
    localparam logic [3:0] ALU_SHRL = 4'd5;
    localparam logic [3:0] ALU_SHRA = 4'd6;
    localparam logic [3:0] ALU_DIFF = 4'd7;

    // reg_write targets
    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_RS    = 2'b01;
    localparam logic [1:0] RW_RT    = 2'b10;
    localparam logic [1:0] RW_R31   = 2'b11;

    // reg_write_mux_ctrl sources
    localparam logic [1:0] WBM_LINK = 2'b00;
    localparam logic [1:0] WBM_MEM  = 2'b01;
    localparam logic [1:0] WBM_ALU  = 2'b10;

    // br_op one-hot bit positions
    localparam int BR_BIT_BR   = 0;
    localparam int BR_BIT_BLTZ = 1;
    localparam int BR_BIT_BZ   = 2;
    localparam int BR_BIT_BNZ  = 3;
    localparam int BR_BIT_BL   = 4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_BRANCH,
        S_HALT,
        S_ERR
    } state_t;

    // Control bundle produced by the decoder; the FSM picks fields per state.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       imm_mux;
        logic       alu_mux;
        logic [1:0] reg_write;
        logic [1:0] wb_mux;
        logic [4:0] br_op;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_nop;
        logic       is_halt;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mini_risc_ctrl_decode.sv
// Purpose: combinational opcode/func -> control bundle map with illegal-instruction flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op/func in (6b each); ctrl out (ctrl_t bundle).
module mini_risc_ctrl_decode
    import mini_risc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                if (func > FN_MAX) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.alu_op    = func[3:0];
                    ctrl.reg_write = RW_RS;
                    ctrl.wb_mux    = WBM_ALU;
                end
            end
            OP_ADDI, OP_COMPI: begin
                ctrl.alu_op    = (op == OP_COMPI) ? ALU_COMP : ALU_ADD;
                ctrl.imm_mux   = 1'b1;
                ctrl.alu_mux   = 1'b1;
                ctrl.reg_write = RW_RS;
                ctrl.wb_mux    = WBM_ALU;
            end
            OP_LW, OP_SW: begin
                // Address = base + immediate
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_mux   = 1'b1;
                ctrl.alu_mux   = 1'b1;
                ctrl.is_load   = (op == OP_LW);
                ctrl.is_store  = (op == OP_SW);
                ctrl.reg_write = (op == OP_LW) ? RW_RT : RW_NONE;
                ctrl.wb_mux    = WBM_MEM;
            end
            OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_BL: begin
                ctrl.is_branch = 1'b1;
                ctrl.br_op     = 5'(5'b00001 << (op - OP_BR));
                if (op == OP_BL) begin
                    ctrl.reg_write = RW_R31;
                    ctrl.wb_mux    = WBM_LINK;
                end
            end
            OP_NOP:  ctrl.is_nop  = 1'b1;
            OP_HALT: ctrl.is_halt = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mini_risc_ctrl_fsm.sv
// Purpose: multi-cycle control sequencer driving the mini-RISC datapath one phase per cycle.
// Latency: R/addi/compi 4, sw 4+wait, lw 5+wait, branch 3, nop 2 cycles.
// Backpressure: stalls in MEM until dmem_ready; MEM_TIMEOUT wait cycles without it -> ERR.
// Ports: clk, rst (async active-high); opcode/func (sampled in DECODE); dmem_ready;
//        ir_load, pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op, dmem_enable,
//        dmem_write_enable, reg_write_mux_ctrl, br_op, halted, err.
// Optional: MINI_RISC_CTRL_PERF_EN adds cycle_cnt / instr_cnt performance counters.
module mini_risc_ctrl_fsm
    import mini_risc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        dmem_ready,
    output logic        ir_load,
    output logic        pc_en,
    output logic [1:0]  reg_write,
    output logic        imm_mux_ctrl,
    output logic        alu_mux_ctrl,
    output logic [3:0]  alu_op,
    output logic        dmem_enable,
    output logic        dmem_write_enable,
    output logic [1:0]  reg_write_mux_ctrl,
    output logic [4:0]  br_op,
    output logic        halted,
`ifdef MINI_RISC_CTRL_PERF_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
`endif
    output logic        err
);

    // Last wait count that may still be followed by another wait cycle
    localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] func_q, func_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] dec_op, dec_func;
    ctrl_t      ctrl;

    // DECODE classifies the live fields it is latching; every other state
    // works from the latched copy so live opcode changes are ignored.
    assign dec_op   = (state_q == S_DECODE) ? opcode : op_q;
    assign dec_func = (state_q == S_DECODE) ? func   : func_q;

    mini_risc_ctrl_decode u_decode (
        .op   (dec_op),
        .func (dec_func),
        .ctrl (ctrl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            func_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            func_q  <= func_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        op_d               = op_q;
        func_d             = func_q;
        cnt_d              = cnt_q;
        ir_load            = 1'b0;
        pc_en              = 1'b0;
        reg_write          = RW_NONE;
        imm_mux_ctrl       = 1'b0;
        alu_mux_ctrl       = 1'b0;
        alu_op             = ALU_ADD;
        dmem_enable        = 1'b0;
        dmem_write_enable  = 1'b0;
        reg_write_mux_ctrl = WBM_LINK;
        br_op              = '0;
        halted             = 1'b0;
        err                = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d   = opcode;
                func_d = func;
                if (ctrl.illegal)        state_d = S_ERR;
                else if (ctrl.is_halt)   state_d = S_HALT;
                else if (ctrl.is_branch) state_d = S_BRANCH;
                else if (ctrl.is_nop) begin
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end else                 state_d = S_EXEC;
            end
            S_EXEC: begin
                imm_mux_ctrl = ctrl.imm_mux;
                alu_mux_ctrl = ctrl.alu_mux;
                alu_op       = ctrl.alu_op;
                cnt_d        = '0;
                state_d      = (ctrl.is_load || ctrl.is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                imm_mux_ctrl      = ctrl.imm_mux;
                alu_mux_ctrl      = ctrl.alu_mux;
                alu_op            = ctrl.alu_op;
                dmem_enable       = 1'b1;
                dmem_write_enable = ctrl.is_store;
                if (dmem_ready) begin
                    if (ctrl.is_store) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB: begin
                imm_mux_ctrl       = ctrl.imm_mux;
                alu_mux_ctrl       = ctrl.alu_mux;
                alu_op             = ctrl.alu_op;
                reg_write          = ctrl.reg_write;
                reg_write_mux_ctrl = ctrl.wb_mux;
                pc_en              = 1'b1;
                state_d            = S_FETCH;
            end
            S_BRANCH: begin
                br_op              = ctrl.br_op;
                reg_write          = ctrl.reg_write;
                reg_write_mux_ctrl = ctrl.wb_mux;
                pc_en              = 1'b1;
                state_d            = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            S_ERR: begin
                halted = 1'b1;
                err    = 1'b1;
            end
            default: state_d = S_ERR;
        endcase

        // Reset forces every control low immediately, including the
        // FETCH-state ir_load and any in-flight memory access.
        if (rst) begin
            ir_load            = 1'b0;
            pc_en              = 1'b0;
            reg_write          = RW_NONE;
            imm_mux_ctrl       = 1'b0;
            alu_mux_ctrl       = 1'b0;
            alu_op             = ALU_ADD;
            dmem_enable        = 1'b0;
            dmem_write_enable  = 1'b0;
            reg_write_mux_ctrl = WBM_LINK;
            br_op              = '0;
            halted             = 1'b0;
            err                = 1'b0;
        end
    end

`ifdef MINI_RISC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_HALT && state_q != S_ERR) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (pc_en)                                 instr_cnt_d = instr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mini_risc_ctrl_fsm.sv
module tb_mini_risc_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        dmem_ready;
    logic        ir_load;
    logic        pc_en;
    logic [1:0]  reg_write;
    logic        imm_mux_ctrl;
    logic        alu_mux_ctrl;
    logic [3:0]  alu_op;
    logic        dmem_enable;
    logic        dmem_write_enable;
    logic [1:0]  reg_write_mux_ctrl;
    logic [4:0]  br_op;
    logic        halted;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mini_risc_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .func               (func),
        .dmem_ready         (dmem_ready),
        .ir_load            (ir_load),
        .pc_en              (pc_en),
        .reg_write          (reg_write),
        .imm_mux_ctrl       (imm_mux_ctrl),
        .alu_mux_ctrl       (alu_mux_ctrl),
        .alu_op             (alu_op),
        .dmem_enable        (dmem_enable),
        .dmem_write_enable  (dmem_write_enable),
        .reg_write_mux_ctrl (reg_write_mux_ctrl),
        .br_op              (br_op),
        .halted             (halted),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output word: {ir_load, pc_en, reg_write, imm, alu_mux, alu_op,
    //                        dmem_en, dmem_we, wb_mux, br_op, halted, err}
    logic [20:0] obs;
    assign obs = {ir_load, pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
                  dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, halted, err};

    typedef struct {
        logic [20:0] v;
        bit          mem;
        bit          rdy;
    } step_t;

    step_t exp_q[$];

    function automatic logic [20:0] vec(bit ir, bit pc, logic [1:0] rw, bit imm, bit am,
                                        logic [3:0] aop, bit de, bit dwe, logic [1:0] wbm,
                                        logic [4:0] br, bit h, bit e);
        return {ir, pc, rw, imm, am, aop, de, dwe, wbm, br, h, e};
    endfunction

    function automatic void push(logic [20:0] v, bit mem, bit rdy);
        step_t s;
        s.v = v; s.mem = mem; s.rdy = rdy;
        exp_q.push_back(s);
    endfunction

    // Reference model: expected per-cycle outputs for one instruction, straight
    // from the instruction-phase table. waits = ready-low MEM cycles before ready.
    function automatic bit build(int op, int fn, int waits);
        bit          legal;
        logic [3:0]  aop;
        bit          imm;
        legal = ((op <= 9) && !(op == 0 && fn > 7)) || op == 62 || op == 63;
        push(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);                       // FETCH
        push(vec(0, legal && op == 62, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);      // DECODE
        if (!legal || op == 63) begin
            for (int k = 0; k < 3; k++)
                push(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, !legal), 0, 0);
            return 1'b1;
        end
        if (op == 62) return 1'b0;
        if (op >= 5) begin
            push(vec(0, 1, (op == 9) ? 2'b11 : 2'b00, 0, 0, 0, 0, 0, 2'b00,
                     5'(1 << (op - 5)), 0, 0), 0, 0);
            return 1'b0;
        end
        aop = (op == 0) ? 4'(fn) : (op == 2) ? 4'd1 : 4'd0;
        imm = (op != 0);
        push(vec(0, 0, 0, imm, imm, aop, 0, 0, 0, 0, 0, 0), 0, 0);                // EXEC
        if (op == 3 || op == 4) begin
            for (int k = 0; k < waits && k < 15; k++)
                push(vec(0, 0, 0, 1, 1, 0, 1, op == 4, 0, 0, 0, 0), 1, 0);
            if (waits >= 15) begin
                for (int k = 0; k < 3; k++)
                    push(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 0, 0);
                return 1'b1;
            end
            push(vec(0, op == 4, 0, 1, 1, 0, 1, op == 4, 0, 0, 0, 0), 1, 1);
            if (op == 4) return 1'b0;
            push(vec(0, 1, 2'b10, 1, 1, 0, 0, 0, 2'b01, 0, 0, 0), 0, 0);          // WB lw
            return 1'b0;
        end
        push(vec(0, 1, 2'b01, imm, imm, aop, 0, 0, 2'b10, 0, 0, 0), 0, 0);        // WB ALU
        return 1'b0;
    endfunction

    // Plays up to ncyc queued cycles. Entry/exit invariant: just after a negedge.
    // Opcode/func are random except in DECODE; dmem_ready is random outside MEM.
    task automatic play(string name, int ncyc, int op, int fn);
        int n;
        n = (ncyc < exp_q.size()) ? ncyc : exp_q.size();
        for (int i = 0; i < n; i++) begin
            opcode     = (i == 1) ? 6'(op) : 6'($urandom);
            func       = (i == 1) ? 6'(fn) : 6'($urandom);
            dmem_ready = exp_q[i].mem ? exp_q[i].rdy : 1'($urandom);
            #1;
            n_checks++;
            if (obs !== exp_q[i].v) begin
                n_errors++;
                $display("FAIL %s cyc%0d: got %b expected %b", name, i, obs, exp_q[i].v);
            end
            @(posedge clk);
            @(negedge clk);
        end
        exp_q.delete();
    endtask

    task automatic apply_reset(string name);
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 21'd0) begin
            n_errors++;
            $display("FAIL %s: outputs in reset got %b expected 0", name, obs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_instr(string name, int op, int fn, int waits);
        bit term;
        term = build(op, fn, waits);
        play(name, 1000, op, fn);
        if (term) apply_reset({name, "_rst"});
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply_reset("reset");
    endtask

    task automatic test_rtype_xor();   run_instr("rtype_xor", 0, 3, 0);  endtask
    task automatic test_lw_wait();     run_instr("lw_wait2", 3, 0, 2);   endtask
    task automatic test_sw_zero_wait(); run_instr("sw_nowait", 4, 0, 0); endtask
    task automatic test_bl();          run_instr("bl", 9, 0, 0);         endtask
    task automatic test_nop();         run_instr("nop", 62, 0, 0);       endtask
    task automatic test_halt();        run_instr("halt", 63, 0, 0);      endtask
    task automatic test_illegal_op();  run_instr("illegal_op20", 20, 0, 0); endtask
    task automatic test_illegal_func(); run_instr("illegal_fn12", 0, 12, 0); endtask
    task automatic test_timeout();     run_instr("mem_timeout", 3, 0, 15); endtask
    task automatic test_wait_limit();  run_instr("lw_wait14", 3, 0, 14); endtask

    task automatic test_reset_mid_mem();
        bit term;
        term = build(3, 0, 10);
        // FETCH, DECODE, EXEC, MEM, MEM
        play("mid_mem_pre", 5, 3, 0);
        dmem_ready = 1'b0;
        #1;
        n_checks++;
        if (dmem_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_mem_en: dmem_enable got %b expected 1", dmem_enable);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 21'd0 || term) begin
            n_errors++;
            $display("FAIL mid_mem_rst: outputs got %b expected 0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        run_instr("after_rst_addi", 1, 0, 0);
    endtask

    task automatic test_random();
        int op, fn, waits, r;
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 99);
            if (r < 88)      op = $urandom_range(0, 9);
            else if (r < 94) op = 62;
            else if (r < 97) op = 63;
            else             op = $urandom_range(10, 61);
            fn    = ($urandom_range(0, 19) == 0) ? $urandom_range(8, 63) : $urandom_range(0, 7);
            waits = ($urandom_range(0, 29) == 0) ? 15 : $urandom_range(0, 4);
            run_instr($sformatf("rand%0d_op%0d_fn%0d_w%0d", t, op, fn, waits), op, fn, waits);
        end
    endtask

    initial begin
        rst        = 1'b1;
        opcode     = '0;
        func       = '0;
        dmem_ready = 1'b0;
        test_reset();
        test_rtype_xor();
        test_lw_wait();
        test_sw_zero_wait();
        test_bl();
        test_nop();
        test_halt();
        test_illegal_op();
        test_illegal_func();
        test_timeout();
        test_wait_limit();
        test_reset_mid_mem();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mini_risc_ctrl_fsm.md
Name: mini_risc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the KGP mini-RISC data_path.
- Consumes opcode_out/func_out from the datapath and drives every datapath control input one instruction phase at a time.
- Adds instruction-register load, PC-update strobes and a data-memory ready handshake, replacing hand-driven control vectors.
- Sits between data_path and the top-level processor wrapper.

Parameters:
- MEM_TIMEOUT, 15, maximum MEM-state wait cycles before flagging err; 4-bit counter width, so legal range is 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  datapath opcode_out; sampled only in DECODE.
- func  in  6  datapath func_out; sampled only in DECODE.
- dmem_ready  in  1  data memory completes the access this cycle.
- ir_load  out  1  instruction register load strobe.
- pc_en  out  1  PC update strobe; the datapath takes pc_new.
- reg_write  out  2  00 none, 01 write rs, 10 write rt, 11 write $31.
- imm_mux_ctrl  out  1  1 = immediate path.
- alu_mux_ctrl  out  1  1 = ALU operand B from immediate.
- alu_op  out  4  0 add, 1 comp, 2 and, 3 xor, 4 shll, 5 shrl, 6 shra, 7 diff.
- dmem_enable  out  1  data memory access.
- dmem_write_enable  out  1  1 = store.
- reg_write_mux_ctrl  out  2  10 ALU result, 01 memory data, 00 pc+1 (link).
- br_op  out  5  one-hot: [0] br, [1] bltz, [2] bz, [3] bnz, [4] bl; 0 = no branch.
- halted  out  1  HALT state reached.
- err  out  1  sticky: illegal opcode/func or memory timeout.

Behaviour:
- Reset (async): state = FETCH. All outputs = 0. Latched opcode/func = 0. Timeout counter = 0. err = 0.
- States:
  - FETCH: ir_load = 1; next = DECODE.
  - DECODE: latch opcode/func into internal registers. All controls 0. Next state:
    - EXEC for R-type (0), addi (1), compi (2), lw (3), sw (4).
    - BRANCH for opcodes 5..9.
    - HALT for 63.
    - NOP (62): go to FETCH with pc_en = 1 in this cycle.
    - Anything else: ERR.
  - EXEC: alu_op and muxes driven from the latched fields; for lw/sw, imm_mux_ctrl = alu_mux_ctrl = 1 and alu_op = 0. Next = MEM for lw/sw, else WB.
  - MEM: dmem_enable = 1; dmem_write_enable = 1 for sw. ALU controls held from EXEC.
    - Stay in MEM while dmem_ready = 0, counting wait cycles.
    - On ready: lw goes to WB; sw goes to FETCH with pc_en = 1 in this cycle.
    - Counter reaching MEM_TIMEOUT with no ready: go to ERR.
  - WB: reg_write pulses for exactly one cycle (01 for R-type/addi/compi, 10 for lw); reg_write_mux_ctrl = 10 (ALU) or 01 (memory); EXEC controls held; pc_en = 1; next = FETCH.
  - BRANCH: br_op = one-hot of opcode-5; pc_en = 1; for bl, additionally reg_write = 11 and reg_write_mux_ctrl = 00. Next = FETCH.
  - HALT: halted = 1, all strobes 0; sticky until rst.
  - ERR: err = 1, halted = 1; sticky until rst.
- R-type func map: 0 add, 1 comp, 2 and, 3 xor, 4 shll, 5 shrl, 6 shra, 7 diff, direct to alu_op. func > 7 goes to ERR (illegal func).
- Latency in cycles: R-type / addi / compi 4; sw 4 + wait; lw 5 + wait; branch 3; nop 2.
- Outputs are functions of state plus latched fields only. A live opcode change outside DECODE has no effect.
- dmem_ready outside MEM is ignored.
- dmem_ready = 1 on the first MEM cycle means zero wait.
- The timeout counter clears on MEM entry.
- rst mid-MEM: dmem_enable drops asynchronously; no partial write-back occurs.

Optional Feature:
- Macro: MINI_RISC_CTRL_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every non-HALT/ERR cycle.
  - instr_cnt increments on each pc_en.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mini_risc_ctrl_pkg: opcode constants, func constants, alu_op codes, reg_write/reg_write_mux encodings, br_op one-hot bits, state enum.
- Sub-module mini_risc_ctrl_decode: combinational map from latched opcode/func to a control bundle plus an illegal flag. The FSM gates this bundle per state.

Test Plan:
- Reset, then R-type xor (op 0, func 3): FETCH ir_load; EXEC alu_op = 3; WB reg_write = 01, mux = 10, pc_en = 1; 4 cycles total.
- lw (op 3) with dmem_ready held low 2 cycles: dmem_enable = 1 for 3 MEM cycles; WB reg_write = 10, mux = 01; 7 cycles total.
- sw (op 4) with ready = 1 immediately: dmem_write_enable = 1 for one cycle; pc_en in MEM; reg_write never nonzero.
- bl (op 9): BRANCH br_op = 5'b10000, reg_write = 11, mux = 00, pc_en = 1; 3 cycles.
- Illegal opcode 20 and func 12 (separate runs): err = 1, halted = 1, no strobes thereafter. MEM with ready low for 15 cycles: err = 1.
- rst asserted during MEM of lw: all outputs 0 immediately; after release, FETCH with ir_load = 1 on the first cycle.
